// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle riscv_cpu: loads instruction memory from a byte
// stream while the core is held in reset, then gates the core through run/halt/step/breakpoint.
module cpu_run_ctrl #(
    parameter int unsigned IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_valid,
    input  logic [7:0]         rx_byte,
    input  logic               load_start,
    input  logic [IMEM_AW:0]   load_len,
    input  logic               run_req,
    input  logic               halt_req,
    input  logic               step_req,
    input  logic               bp_en,
    input  logic [31:0]        bp_addr,
    input  logic [31:0]        cpu_pc,
    output logic               cpu_reset,
    output logic               cpu_clk_en,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               load_done,
    output logic [2:0]         state,
    output logic [31:0]        instr_count
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StHalt = 3'd2,
        StRun  = 3'd3,
        StStep = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0] waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               load_done_q, load_done_d;
    logic [31:0]        icnt_q, icnt_d;
    logic [1:0]         bc_q, bc_d;
    // Word count is one bit wider than the address so it can reach load_len; the address wraps.
    logic [IMEM_AW:0]   wc_q, wc_d;
    logic [IMEM_AW:0]   len_q, len_d;
    logic [31:0]        asm_q, asm_d;
    logic               first_q, first_d;
    logic               bp_hit;
    logic               enter_load;

    // The first RUN cycle ignores the breakpoint so a resume executes the breakpointed instruction.
    assign bp_hit     = bp_en && (cpu_pc == bp_addr) && !first_q;
    assign cpu_clk_en = ((state_q == StRun) && !bp_hit) || (state_q == StStep);
    assign enter_load = load_start &&
                        ((state_q == StIdle) || (state_q == StLoad) || (state_q == StHalt));

    always_comb begin
        state_d     = state_q;
        imem_we_d   = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        load_done_d = 1'b0;
        icnt_d      = icnt_q + 32'(cpu_clk_en);
        bc_d        = bc_q;
        wc_d        = wc_q;
        len_d       = len_q;
        asm_d       = asm_q;
        first_d     = 1'b0;

        if (enter_load) begin
            state_d = StLoad;
            bc_d    = 2'd0;
            wc_d    = '0;
            icnt_d  = 32'd0;
            len_d   = load_len;
            asm_d   = 32'd0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLoad: begin
                    if (wc_q == len_q) begin
                        state_d     = StHalt;
                        load_done_d = 1'b1;
                    end else if (rx_valid) begin
                        asm_d[{bc_q, 3'b000} +: 8] = rx_byte;
                        bc_d = bc_q + 2'd1;
                        if (bc_q == 2'd3) begin
                            imem_we_d = 1'b1;
                            waddr_d   = wc_q[IMEM_AW-1:0];
                            wdata_d   = asm_d;
                            wc_d      = wc_q + 1'b1;
                        end
                    end
                end
                StHalt: begin
                    if (run_req) begin
                        state_d = StRun;
                        first_d = 1'b1;
                    end else if (step_req) begin
                        state_d = StStep;
                    end
                end
                StRun: begin
                    if (bp_hit || halt_req) begin
                        state_d = StHalt;
                    end
                end
                StStep:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end

        cpu_reset_d = (state_d == StIdle) || (state_d == StLoad);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cpu_reset_q <= 1'b1;
            imem_we_q   <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= 32'd0;
            load_done_q <= 1'b0;
            icnt_q      <= 32'd0;
            bc_q        <= 2'd0;
            wc_q        <= '0;
            len_q       <= '0;
            asm_q       <= 32'd0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_reset_q <= cpu_reset_d;
            imem_we_q   <= imem_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            load_done_q <= load_done_d;
            icnt_q      <= icnt_d;
            bc_q        <= bc_d;
            wc_q        <= wc_d;
            len_q       <= len_d;
            asm_q       <= asm_d;
            first_q     <= first_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign imem_we     = imem_we_q;
    assign imem_waddr  = waddr_q;
    assign imem_wdata  = wdata_q;
    assign load_done   = load_done_q;
    assign state       = state_q;
    assign instr_count = icnt_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run-control sequencer for the single-cycle riscv_cpu.
- Loads a program into instruction memory from a byte stream, such as a UART receiver, while the core is held in reset.
- Then releases the core and gates its execution through halt, run, single-step and one PC breakpoint.
- Sits between the board-level loader/debug logic and the CPU's reset and clock-enable inputs plus the instruction memory write port.

Parameters:
IMEM_AW, 8, instruction memory word-address width (2^IMEM_AW words)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx_valid  input  1  rx_byte valid this cycle
rx_byte  input  8  program byte, little-endian within each word
load_start  input  1  pulse: begin program load
load_len  input  IMEM_AW+1  number of words to load, sampled at load_start
run_req  input  1  pulse: free-run
halt_req  input  1  pulse: stop execution
step_req  input  1  pulse: execute exactly one instruction
bp_en  input  1  breakpoint enable
bp_addr  input  32  breakpoint PC
cpu_pc  input  32  current PC from core
cpu_reset  output  1  active-high reset to core, registered
cpu_clk_en  output  1  core state-update enable, combinational
imem_we  output  1  instruction memory write strobe, registered
imem_waddr  output  IMEM_AW  word address
imem_wdata  output  32  write data
load_done  output  1  one-cycle pulse when load completes
state  output  3  IDLE=0, LOAD=1, HALT=2, RUN=3, STEP=4
instr_count  output  32  number of cycles with cpu_clk_en=1

Behaviour:
Reset values (reset low, asynchronous):
- state=IDLE, cpu_reset=1, imem_we=0.
- imem_waddr=0, imem_wdata=0, load_done=0, instr_count=0.
- Byte and word counters = 0.

IDLE:
- cpu_reset=1, cpu_clk_en=0.
- load_start -> LOAD. All other requests are ignored.

LOAD:
- cpu_reset=1, cpu_clk_en=0.
- Entry clears the byte counter (bc), the word counter (wc) and instr_count, and latches load_len.
- If the latched length is 0, go straight to HALT with load_done pulsed.
- Each cycle with rx_valid=1 places rx_byte at bits [8*bc+7:8*bc] of a 32-bit assembly register and increments bc (2-bit, wraps).
- When the byte with bc=3 arrives, the next cycle has:
  - imem_we=1 for exactly one cycle;
  - imem_waddr=wc, with imem_wdata equal to the assembled word;
  - wc incremented.
- After the write of word load_len-1: state becomes HALT on the cycle following that write, with load_done=1 for that one cycle.
- rx_valid is ignored outside LOAD.
- run_req, halt_req and step_req are ignored in LOAD.
- load_start in LOAD restarts the load (counters cleared).
- wc wraps modulo 2^IMEM_AW if load_len exceeds the memory depth.

HALT:
- cpu_reset=0, cpu_clk_en=0.
- Request priority: load_start > run_req > step_req.
- load_start -> LOAD, which reasserts cpu_reset so the PC returns to 0.
- run_req -> RUN. step_req -> STEP.

RUN:
- cpu_clk_en = 1, except that it is forced to 0 when bp_en=1, cpu_pc==bp_addr, and this is not the first RUN cycle.
- The first RUN cycle after HALT masks the breakpoint, so resuming from a breakpoint executes the instruction at that address.
- Breakpoint hit -> HALT next cycle; the breakpointed instruction does not execute.
- halt_req -> HALT next cycle; cpu_clk_en remains 1 during the halt_req cycle.
- load_start is ignored in RUN.

STEP:
- cpu_clk_en=1 for exactly one cycle, with no breakpoint check, then HALT.

General:
- instr_count increments on every cycle with cpu_clk_en=1 and wraps at 2^32.
- Deassertion of cpu_reset occurs only on a registered transition into HALT.
- Reset asserted mid-load or mid-run returns immediately to IDLE; partially assembled words are discarded.

Test Plan:
- Load 2 words: load_start with load_len=2, then bytes 13,00,50,00,93,00,10,00 → imem_we pulses twice: addr0=0x00500013, addr1=0x00100093; load_done once; state=HALT; cpu_reset falls.
- Gapped bytes plus stray traffic: rx_valid high every third cycle, plus rx_valid pulses in IDLE → only LOAD bytes are assembled; no writes in IDLE.
- Step: in HALT, issue step_req 3 times → exactly 3 cycles of cpu_clk_en=1; instr_count=3; state returns to HALT after each.
- Breakpoint: bp_en=1, bp_addr=0x8; run_req from PC 0 → cpu_clk_en is low when cpu_pc=0x8; state=HALT; a second run_req executes 0x8 and continues.
- Halt, request priority and zero length: halt_req during RUN stops execution the next cycle; run_req and step_req in the same HALT cycle → RUN; load_len=0 → immediate HALT with load_done and no imem_we.
- Async reset mid-load after 5 bytes → all outputs take reset values immediately; a new load then writes from addr 0.
